// File: rtl/track_pkg.sv
// rtl/track_pkg.sv - direction/state encodings and tie-break helper for the orange track controller
package track_pkg;

    typedef enum logic [2:0] {
        DIR_NONE   = 3'b000,
        DIR_LEFT   = 3'b001,
        DIR_RIGHT  = 3'b010,
        DIR_CENTER = 3'b011,
        DIR_STOP   = 3'b100
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_SEND   = 3'd4
    } state_e;

    // Argmax over the three vote counts; ties resolve CENTER, then LEFT, then RIGHT.
    function automatic dir_e pick_dir(input logic [31:0] center,
                                      input logic [31:0] left,
                                      input logic [31:0] right);
        if (center >= left && center >= right) begin
            return DIR_CENTER;
        end else if (left >= right) begin
            return DIR_LEFT;
        end else begin
            return DIR_RIGHT;
        end
    endfunction

endpackage

// File: rtl/sig_edge_detect.sv
// rtl/sig_edge_detect.sv - single-register sampler with a rise or fall pulse output
module sig_edge_detect #(
    parameter bit FALL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic edge_o
);

    logic cur_q;
    logic prev_q;

    // Sample the raw signal once and keep the previous sample for edge comparison
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            cur_q  <= sig_i;
            prev_q <= cur_q;
        end
    end

    assign edge_o = FALL ? (prev_q & ~cur_q) : (cur_q & ~prev_q);

endmodule

// File: rtl/orange_track_controller.sv
// rtl/orange_track_controller.sv - per-frame direction voting, persistence filter and command handshake (optional TRACK_TIMEOUT_EN)
module orange_track_controller
    import track_pkg::*;
#(
    parameter int VOTE_W         = 9,
    parameter int MIN_VOTES      = 8,
`ifdef TRACK_TIMEOUT_EN
    parameter int TIMEOUT_FRAMES = 15,
`endif
    parameter int PERSIST        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       vsync,
    input  logic       href,
    input  logic       line_detect,
    input  logic [2:0] line_dir,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_dir,
    output logic       frame_done,
    output logic       busy,
    output logic [7:0] drop_count
);

    localparam int PW = $clog2(PERSIST + 1);
    localparam int SW = VOTE_W + 2;
    localparam logic [PW-1:0] PERSIST_V = PW'(PERSIST);

    state_e            state_q, state_d;
    logic              href_fall;
    logic              vsync_rise;
    logic              line_det_q;
    logic [2:0]        line_dir_q;
    logic              vote_left, vote_right, vote_center;
    logic              cnt_clr, cnt_en;
    logic [VOTE_W-1:0] left_q, left_d;
    logic [VOTE_W-1:0] right_q, right_d;
    logic [VOTE_W-1:0] center_q, center_d;
    logic [SW-1:0]     total;
    dir_e              cand;
    dir_e              last_cand_q, last_cand_d;
    logic [PW-1:0]     persist_q, persist_d, persist_step;
    logic              persist_commit;
    logic              commit;
    dir_e              commit_dir;
    dir_e              cmd_dir_q, cmd_dir_d;
    logic [7:0]        drop_q, drop_d;
`ifdef TRACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT_FRAMES);
    logic [TW-1:0]     timeout_q, timeout_d;
`endif

    function automatic logic [VOTE_W-1:0] sat_inc(input logic [VOTE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    sig_edge_detect #(.FALL(1'b1)) u_href_edge (
        .clk_i  (clk),
        .rst_i  (reset),
        .sig_i  (href),
        .edge_o (href_fall)
    );

    sig_edge_detect #(.FALL(1'b0)) u_vsync_edge (
        .clk_i  (clk),
        .rst_i  (reset),
        .sig_i  (vsync),
        .edge_o (vsync_rise)
    );

    // Classifier outputs take the same one-register delay as href so they line up with the fall pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_det_q <= 1'b0;
            line_dir_q <= 3'b000;
        end else begin
            line_det_q <= line_detect;
            line_dir_q <= line_dir;
        end
    end

    assign vote_left   = href_fall & line_det_q & (line_dir_q == DIR_LEFT);
    assign vote_right  = href_fall & line_det_q & (line_dir_q == DIR_RIGHT);
    assign vote_center = href_fall & line_det_q & (line_dir_q == DIR_CENTER);

    // When counters restart and when a line vote may land; a line ending in DECIDE opens the next frame
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_SYNC: begin
                cnt_clr = vsync_rise;
            end
            ST_ACCUM: begin
                cnt_clr = !vsync_rise && !enable;
                cnt_en  = vsync_rise || enable;
            end
            ST_DECIDE: begin
                cnt_clr = 1'b1;
                cnt_en  = 1'b1;
            end
            ST_SEND: begin
                cnt_clr = vsync_rise;
                cnt_en  = !vsync_rise;
            end
            default: begin
                cnt_clr = 1'b0;
                cnt_en  = 1'b0;
            end
        endcase
    end

    // Saturating vote counters
    always_comb begin
        left_d   = cnt_clr ? '0 : left_q;
        right_d  = cnt_clr ? '0 : right_q;
        center_d = cnt_clr ? '0 : center_q;
        if (cnt_en && vote_left) begin
            left_d = sat_inc(left_d);
        end
        if (cnt_en && vote_right) begin
            right_d = sat_inc(right_d);
        end
        if (cnt_en && vote_center) begin
            center_d = sat_inc(center_d);
        end
    end

    // Frame decision, persistence filter and commit selection evaluated in DECIDE
    always_comb begin
        total = SW'(left_q) + SW'(right_q) + SW'(center_q);
        if (total < SW'(MIN_VOTES)) begin
            cand = DIR_NONE;
        end else begin
            cand = pick_dir(32'(center_q), 32'(left_q), 32'(right_q));
        end

        if (cand == last_cand_q) begin
            persist_step = (persist_q >= PERSIST_V) ? persist_q : persist_q + 1'b1;
        end else begin
            persist_step = PW'(1);
        end
        persist_commit = (persist_step >= PERSIST_V) && (cand != cmd_dir_q);

        last_cand_d = last_cand_q;
        persist_d   = persist_q;
        cmd_dir_d   = cmd_dir_q;
        commit      = 1'b0;
        commit_dir  = cand;
`ifdef TRACK_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        if (state_q == ST_DECIDE) begin
`ifdef TRACK_TIMEOUT_EN
            if (cand == DIR_NONE) begin
                // Empty frames hold the last command; STOP fires once when the run reaches the limit
                if (timeout_q != TIMEOUT_V) begin
                    timeout_d = timeout_q + 1'b1;
                    if (timeout_d == TIMEOUT_V && cmd_dir_q != DIR_STOP) begin
                        commit     = 1'b1;
                        commit_dir = DIR_STOP;
                    end
                end
            end else begin
                timeout_d   = '0;
                last_cand_d = cand;
                persist_d   = persist_step;
                commit      = persist_commit;
            end
`else
            last_cand_d = cand;
            persist_d   = persist_step;
            commit      = persist_commit;
`endif
            if (commit) begin
                cmd_dir_d = commit_dir;
            end
        end
    end

    // A frame end while a command is still pending is dropped and counted
    always_comb begin
        drop_d = drop_q;
        if (state_q == ST_SEND && vsync_rise && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (vsync_rise)   state_d = ST_ACCUM;
                else if (!enable) state_d = ST_IDLE;
            end
            ST_ACCUM: begin
                if (vsync_rise)   state_d = ST_DECIDE;
                else if (!enable) state_d = ST_IDLE;
            end
            ST_DECIDE: begin
                state_d = commit ? ST_SEND : ST_ACCUM;
            end
            ST_SEND: begin
                if (cmd_ready) state_d = ST_ACCUM;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        cmd_valid  = (state_q == ST_SEND);
        frame_done = (state_q == ST_DECIDE);
        busy       = (state_q != ST_IDLE);
        cmd_dir    = cmd_dir_q;
        drop_count = drop_q;
    end

    // Datapath registers: vote counters, persistence, committed direction, drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_q      <= '0;
            right_q     <= '0;
            center_q    <= '0;
            last_cand_q <= DIR_NONE;
            persist_q   <= '0;
            cmd_dir_q   <= DIR_NONE;
            drop_q      <= 8'd0;
        end else begin
            left_q      <= left_d;
            right_q     <= right_d;
            center_q    <= center_d;
            last_cand_q <= last_cand_d;
            persist_q   <= persist_d;
            cmd_dir_q   <= cmd_dir_d;
            drop_q      <= drop_d;
        end
    end

`ifdef TRACK_TIMEOUT_EN
    // Consecutive empty-frame counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= '0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_orange_track_controller.sv
// tb/tb_orange_track_controller.sv - scoreboard bench for orange_track_controller
`timescale 1ns/1ps
module tb_orange_track_controller;

    localparam logic [2:0] D_NONE   = 3'b000;
    localparam logic [2:0] D_LEFT   = 3'b001;
    localparam logic [2:0] D_RIGHT  = 3'b010;
    localparam logic [2:0] D_CENTER = 3'b011;
    localparam logic [2:0] D_STOP   = 3'b100;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       vsync;
    logic       href;
    logic       line_detect;
    logic [2:0] line_dir;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_dir;
    logic       frame_done;
    logic       busy;
    logic [7:0] drop_count;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q[$];
    logic       prev_hold = 1'b0;
    logic [2:0] prev_dir  = 3'b000;

    always #5 clk = ~clk;

    orange_track_controller dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .vsync       (vsync),
        .href        (href),
        .line_detect (line_detect),
        .line_dir    (line_dir),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_dir     (cmd_dir),
        .frame_done  (frame_done),
        .busy        (busy),
        .drop_count  (drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected command on every accepted handshake, and checks valid/dir hold under backpressure
    always @(negedge clk) begin
        logic [2:0] e;
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) check("cmd_hold", {cmd_valid, cmd_dir}, {1'b1, prev_dir});
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cmd_unexpected: got dir 0x%0h, required no command", cmd_dir);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_dir", cmd_dir, e);
                end
            end
            prev_hold = cmd_valid && !cmd_ready;
            prev_dir  = cmd_dir;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; vsync = 1'b0; href = 1'b0;
        line_detect = 1'b0; line_dir = 3'b000;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic lines(input int n, input logic det, input logic [2:0] dir);
        repeat (n) begin
            line_detect = det; line_dir = dir; href = 1'b1;
            tick(1);
            href = 1'b0;
            tick(2);
        end
    endtask

    // Frame end: optional final line whose href fall coincides with the vsync rise, then latency checks
    task automatic frame_end(input string tag, input logic exp_fd, input logic exp_cv, input logic with_line);
        if (with_line) begin
            href = 1'b1;
            tick(1);
            href = 1'b0;
        end
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
        check($sformatf("%s_fd_t1", tag), frame_done, 1'b0);
        tick(1);
        check($sformatf("%s_fd_t2", tag), frame_done, exp_fd);
        tick(1);
        check($sformatf("%s_cv_t3", tag), cmd_valid, exp_cv);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; vsync = 1'b0; href = 1'b0;
        line_detect = 1'b0; line_dir = 3'b000; cmd_ready = 1'b0;
        tick(2);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd_dir", cmd_dir, D_NONE);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop_count, 8'd0);
        reset = 1'b0;
        tick(1);

        // Reset while a command is pending
        enable = 1'b1;
        tick(1);
        check("t1_busy", busy, 1'b1);
        frame_end("t1_sync", 1'b0, 1'b0, 1'b0);
        lines(10, 1'b1, D_RIGHT);
        frame_end("t1_f1", 1'b1, 1'b0, 1'b0);
        lines(10, 1'b1, D_RIGHT);
        frame_end("t1_f2", 1'b1, 1'b1, 1'b0);
        tick(2);
        check("t1_pending_dir", cmd_dir, D_RIGHT);
        reset = 1'b1;
        #1;
        check("t1_rst_valid", cmd_valid, 1'b0);
        check("t1_rst_dir", cmd_dir, D_NONE);
        check("t1_rst_busy", busy, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // Minimum votes, persistence, invalid codes, vote threshold boundary
        cmd_ready = 1'b1;
        enable = 1'b1;
        frame_end("t2_sync", 1'b0, 1'b0, 1'b0);
        lines(20, 1'b1, D_LEFT);
        lines(5, 1'b1, D_RIGHT);
        frame_end("t2_f1", 1'b1, 1'b0, 1'b0);
        lines(20, 1'b1, D_LEFT);
        lines(5, 1'b1, D_RIGHT);
        exp_q.push_back(D_LEFT);
        frame_end("t2_f2", 1'b1, 1'b1, 1'b0);
        tick(1);
        for (int f = 0; f < 2; f++) begin
            lines(10, 1'b0, D_LEFT);
            lines(10, 1'b1, 3'b111);
            lines(10, 1'b1, D_STOP);
            lines(8, 1'b1, D_RIGHT);
            if (f == 1) exp_q.push_back(D_RIGHT);
            frame_end($sformatf("t2_min8_%0d", f), 1'b1, f == 1, 1'b0);
        end
        tick(1);
        lines(7, 1'b1, D_LEFT);
        frame_end("t2_min7_0", 1'b1, 1'b0, 1'b0);
        lines(7, 1'b1, D_LEFT);
`ifdef TRACK_TIMEOUT_EN
        frame_end("t2_min7_1", 1'b1, 1'b0, 1'b0);
`else
        exp_q.push_back(D_NONE);
        frame_end("t2_min7_1", 1'b1, 1'b1, 1'b0);
`endif
        tick(2);

        // Ties
        do_reset();
        cmd_ready = 1'b1;
        enable = 1'b1;
        frame_end("t3_sync", 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 2; f++) begin
            lines(30, 1'b1, D_LEFT);
            lines(30, 1'b1, D_CENTER);
            if (f == 1) exp_q.push_back(D_CENTER);
            frame_end($sformatf("t3_cl_%0d", f), 1'b1, f == 1, 1'b0);
        end
        tick(1);
        for (int f = 0; f < 2; f++) begin
            lines(30, 1'b1, D_RIGHT);
            lines(30, 1'b1, D_LEFT);
            if (f == 1) exp_q.push_back(D_LEFT);
            frame_end($sformatf("t3_lr_%0d", f), 1'b1, f == 1, 1'b0);
        end
        tick(2);

        // Backpressure with dropped decisions
        do_reset();
        cmd_ready = 1'b0;
        enable = 1'b1;
        frame_end("t4_sync", 1'b0, 1'b0, 1'b0);
        lines(10, 1'b1, D_RIGHT);
        frame_end("t4_f1", 1'b1, 1'b0, 1'b0);
        lines(10, 1'b1, D_RIGHT);
        frame_end("t4_f2", 1'b1, 1'b1, 1'b0);
        lines(10, 1'b1, D_RIGHT);
        frame_end("t4_drop1", 1'b0, 1'b1, 1'b0);
        check("t4_drop_count1", drop_count, 8'd1);
        lines(10, 1'b1, D_RIGHT);
        frame_end("t4_drop2", 1'b0, 1'b1, 1'b0);
        check("t4_dir_stable", cmd_dir, D_RIGHT);
        enable = 1'b0;
        tick(3);
        check("t4_valid_no_abort", cmd_valid, 1'b1);
        exp_q.push_back(D_RIGHT);
        cmd_ready = 1'b1;
        tick(1);
        tick(3);
        check("t4_drop_count2", drop_count, 8'd2);
        check("t4_idle_busy", busy, 1'b0);
        check("t4_idle_valid", cmd_valid, 1'b0);

        // Counter saturation and coincident href fall / vsync rise
        do_reset();
        cmd_ready = 1'b1;
        enable = 1'b1;
        frame_end("t5_sync", 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 2; f++) begin
            lines(600, 1'b1, D_CENTER);
            lines(100, 1'b1, D_LEFT);
            if (f == 1) exp_q.push_back(D_CENTER);
            frame_end($sformatf("t5_sat_%0d", f), 1'b1, f == 1, 1'b0);
        end
        tick(1);
        for (int f = 0; f < 2; f++) begin
            lines(7, 1'b1, D_LEFT);
            if (f == 1) exp_q.push_back(D_LEFT);
            frame_end($sformatf("t5_edge_%0d", f), 1'b1, f == 1, 1'b1);
        end
        tick(2);

        // Empty frames after a committed direction
        do_reset();
        cmd_ready = 1'b1;
        enable = 1'b1;
        frame_end("t6_sync", 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 2; f++) begin
            lines(10, 1'b1, D_LEFT);
            if (f == 1) exp_q.push_back(D_LEFT);
            frame_end($sformatf("t6_left_%0d", f), 1'b1, f == 1, 1'b0);
        end
        tick(1);
`ifdef TRACK_TIMEOUT_EN
        for (int f = 1; f <= 14; f++) begin
            frame_end($sformatf("t6_empty_%0d", f), 1'b1, 1'b0, 1'b0);
        end
        exp_q.push_back(D_STOP);
        frame_end("t6_empty_15", 1'b1, 1'b1, 1'b0);
        tick(1);
        frame_end("t6_empty_16", 1'b1, 1'b0, 1'b0);
        frame_end("t6_empty_17", 1'b1, 1'b0, 1'b0);
`else
        frame_end("t6_empty_1", 1'b1, 1'b0, 1'b0);
        exp_q.push_back(D_NONE);
        frame_end("t6_empty_2", 1'b1, 1'b1, 1'b0);
        tick(1);
        frame_end("t6_empty_3", 1'b1, 1'b0, 1'b0);
`endif
        tick(5);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
